mem_bus_arbiter: RTL

- Shares the 7-bit address / 8-bit bidirectional data memory bus (`address_bus`, `data_bus`, `read_n`, `write_n`) between two requesters. Requester 0 is the SPI slave controller; requester 1 is the local host or test port.
- Each requester presents a complete read or write transaction under a req/gnt/done handshake.
- The arbiter alone sequences the bus strobes with fixed setup, strobe and hold phases. Arbitration is round-robin.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // Transaction direction as presented on rw0/rw1.
  localparam logic RW_READ = 1'b1;

  // Bus sequencing phases: IDLE -> SETUP -> STROBE (xN) -> HOLD -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select. A lone request always wins; on a tie
// the requester that was not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  // Combinational winner decode.
  always_comb begin
    // NOTE: every output is assigned a default first so no latch is inferred.
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 7-bit address / 8-bit data memory bus between two requesters.
// Requester 0 is the SPI slave controller, requester 1 the local host/test
// port. The arbiter alone sequences the strobes: one SETUP cycle, then
// STROBE_CYCLES cycles with read_n or write_n low, then one HOLD cycle in
// which done pulses. All outputs except the data_bus enable are registered;
// the enable is decoded from registered state so reset releases it at once.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              read_n,
  output logic              write_n,
  output logic              busy
);

  // Strobe counter counts down from STROBE_CYCLES-1 to 0; it never wraps.
  localparam int                CNT_W    = $clog2(STROBE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // FSM and transaction registers.
  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic                owner_q,      owner_d;
  logic                rw_q,         rw_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   rdata_q,      rdata_d;

  // Registered outputs.
  logic gnt0_q,    gnt0_d;
  logic gnt1_q,    gnt1_d;
  logic done0_q,   done0_d;
  logic done1_q,   done1_d;
  logic busy_q,    busy_d;
  logic read_n_q,  read_n_d;
  logic write_n_q, write_n_d;

  // Arbitration result, only consumed in IDLE.
  logic any_req;
  logic winner;
  logic drive_en;

  rr_pick2 u_rr_pick2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // State and transaction registers; reset loses any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      rw_q         <= RW_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic: latch the winner's request in IDLE, then walk the phases.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SETUP;
          owner_d = winner;
          rw_d    = winner ? rw1    : rw0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          // Capture memory data on the edge that ends the last strobe cycle.
          if (rw_q == RW_READ) begin
            rdata_d = data_bus;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        state_d      = IDLE;
        last_grant_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every bus output comes from a flop.
  always_comb begin
    busy_d    = (state_d != IDLE);
    gnt0_d    = busy_d && !owner_d;
    gnt1_d    = busy_d &&  owner_d;
    done0_d   = (state_d == HOLD) && !owner_d;
    done1_d   = (state_d == HOLD) &&  owner_d;
    read_n_d  = !((state_d == STROBE) && (rw_d == RW_READ));
    write_n_d = !((state_d == STROBE) && (rw_d != RW_READ));
  end

  // Output registers; strobes idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
    end else begin
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
    end
  end

  // The data driver is on only for a granted write; read_n can never be low
  // then, so the arbiter and the memory never fight over data_bus.
  assign drive_en = (state_q != IDLE) && (rw_q != RW_READ);
  assign data_bus = drive_en ? wdata_q : {DATA_W{1'bz}};

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign busy        = busy_q;
  assign read_n      = read_n_q;
  assign write_n     = write_n_q;
  assign address_bus = addr_q;
  assign rdata       = rdata_q;

endmodule
